// File: rtl/coil_phase_decoder.sv
// coil_phase_decoder: receive-side monitor for the two-phase stepper coil bus.
// Synchronises and debounces the coil pattern, decodes each accepted phase
// change into a step event with direction, and keeps a signed position count,
// an idle/moving indication and illegal/skip error flags.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   coil_in[3:0]  coil pattern (A B A' B'), asynchronous to clk
//   clear         synchronous clear of position and sticky error flags
//   step_pulse    one-cycle pulse per legal step
//   step_dir      direction of the last step (1 = 0011->0110->1100->1001)
//   position      two's-complement step count
//   phase_idx     index of the last accepted legal phase
//   active        last accepted pattern is an energised legal phase
//   moving        a step was accepted within the last IDLE_TIMEOUT cycles
//   err_pulse     one-cycle pulse on an illegal pattern or skipped phase
//   err_illegal   sticky illegal-pattern flag
//   err_skip      sticky skipped-phase flag
module coil_phase_decoder #(
  parameter int unsigned POS_W        = 16,
  parameter int unsigned STABLE_CYC   = 2,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       coil_in,
  input  logic             clear,
  output logic             step_pulse,
  output logic             step_dir,
  output logic [POS_W-1:0] position,
  output logic [1:0]       phase_idx,
  output logic             active,
  output logic             moving,
  output logic             err_pulse,
  output logic             err_illegal,
  output logic             err_skip
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  STABLE_MAX = CNT_W'(STABLE_CYC);
  localparam logic [IDLE_W-1:0] IDLE_LOAD  = IDLE_W'(IDLE_TIMEOUT);

  // {legal, idx} for a coil pattern
  function automatic logic [2:0] phase_of(input logic [3:0] p);
    case (p)
      4'b0011: return 3'b100;
      4'b0110: return 3'b101;
      4'b1100: return 3'b110;
      4'b1001: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  logic [3:0]        s1_q, s2_q;
  logic [3:0]        cand_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        acc_q;
  logic [IDLE_W-1:0] idle_q;

  logic              accept_c;
  logic [2:0]        p_dec_c, q_dec_c;
  logic [1:0]        diff_c;

  logic              step_n, dir_n, act_n, mov_n, err_n, ill_n, skip_n;
  logic              set_ill_c, set_skip_c;
  logic [POS_W-1:0]  pos_n;
  logic [1:0]        idx_n;
  logic [3:0]        acc_n;
  logic [IDLE_W-1:0] idle_n;

  // Two-flop synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= coil_in;
      s2_q <= s1_q;
    end
  end

  // Stability filter: candidate pattern and saturating run-length count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else if (s2_q != cand_q) begin
      cand_q <= s2_q;
      cnt_q  <= CNT_W'(1);
    end else if (cnt_q < STABLE_MAX) begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // Candidate stable long enough and new relative to the accepted pattern
  assign accept_c = (cnt_q == STABLE_MAX) && (cand_q != acc_q);
  assign p_dec_c  = phase_of(cand_q);
  assign q_dec_c  = phase_of(acc_q);
  assign diff_c   = p_dec_c[1:0] - q_dec_c[1:0];

  // Decode and next-state computation
  always_comb begin
    step_n     = 1'b0;
    err_n      = 1'b0;
    dir_n      = step_dir;
    pos_n      = position;
    idx_n      = phase_idx;
    act_n      = active;
    mov_n      = moving;
    acc_n      = acc_q;
    idle_n     = idle_q;
    set_ill_c  = 1'b0;
    set_skip_c = 1'b0;

    if (accept_c) begin
      acc_n = cand_q;
      if (cand_q == 4'b0000) begin
        act_n = 1'b0;
      end else if (p_dec_c[2]) begin
        act_n = 1'b1;
        idx_n = p_dec_c[1:0];
        // A previous non-phase pattern means there is no reference to step from
        if (q_dec_c[2]) begin
          case (diff_c)
            2'd1: begin
              step_n = 1'b1;
              dir_n  = 1'b1;
              pos_n  = position + POS_W'(1);
            end
            2'd3: begin
              step_n = 1'b1;
              dir_n  = 1'b0;
              pos_n  = position - POS_W'(1);
            end
            default: begin
              err_n      = 1'b1;
              set_skip_c = 1'b1;
            end
          endcase
        end
      end else begin
        err_n     = 1'b1;
        set_ill_c = 1'b1;
        act_n     = 1'b0;
      end
    end

    // Clear wins over a same-cycle step, but a same-cycle error still latches
    if (clear) begin
      pos_n = '0;
    end
    ill_n  = (err_illegal & ~clear) | set_ill_c;
    skip_n = (err_skip & ~clear) | set_skip_c;

    // Idle timer: reloaded by each step, moving drops when it expires
    if (step_n) begin
      idle_n = IDLE_LOAD;
      mov_n  = 1'b1;
    end else if (idle_q != '0) begin
      idle_n = idle_q - IDLE_W'(1);
      if (idle_q == IDLE_W'(1)) begin
        mov_n = 1'b0;
      end
    end
  end

  // Output and decode state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_pulse  <= 1'b0;
      step_dir    <= 1'b0;
      position    <= '0;
      phase_idx   <= '0;
      active      <= 1'b0;
      moving      <= 1'b0;
      err_pulse   <= 1'b0;
      err_illegal <= 1'b0;
      err_skip    <= 1'b0;
      acc_q       <= '0;
      idle_q      <= '0;
    end else begin
      step_pulse  <= step_n;
      step_dir    <= dir_n;
      position    <= pos_n;
      phase_idx   <= idx_n;
      active      <= act_n;
      moving      <= mov_n;
      err_pulse   <= err_n;
      err_illegal <= ill_n;
      err_skip    <= skip_n;
      acc_q       <= acc_n;
      idle_q      <= idle_n;
    end
  end

endmodule

// File: tb/tb_coil_phase_decoder.sv
// Scoreboard bench for coil_phase_decoder: directed sequences plus a random
// walk of coil patterns, checked against a pattern-level reference model.
module tb_coil_phase_decoder;

  localparam int S    = 2;
  localparam int IDLE = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  coil_in = 4'b0000;
  logic        clear = 1'b0;
  logic        step_pulse, step_dir, active, moving, err_pulse, err_illegal, err_skip;
  logic [15:0] position;
  logic [1:0]  phase_idx;

  coil_phase_decoder #(.POS_W(16), .STABLE_CYC(S), .IDLE_TIMEOUT(IDLE)) dut (
    .clk(clk), .rst_n(rst_n), .coil_in(coil_in), .clear(clear),
    .step_pulse(step_pulse), .step_dir(step_dir), .position(position),
    .phase_idx(phase_idx), .active(active), .moving(moving),
    .err_pulse(err_pulse), .err_illegal(err_illegal), .err_skip(err_skip)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    bit          is_err;
    bit          dir;
    logic [15:0] pos;
    logic [1:0]  idx;
    bit          act;
    bit          ill;
    bit          skip;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  logic [3:0]  m_acc = 4'b0000;
  logic [15:0] m_pos = 16'h0000;
  bit          m_dir = 0, m_act = 0, m_ill = 0, m_skip = 0;
  logic [1:0]  m_idx = 2'd0;
  logic [3:0]  last_pat = 4'b0000;
  int          last_step = 0;
  bit          step_seen = 0;
  logic [3:0]  phases [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};

  function automatic int pidx(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (phases[i] == p) return i;
    return -1;
  endfunction

  // Apply one accepted pattern to the model; predicted pulse cycle is k+3+S
  task automatic model_accept(input logic [3:0] p, input int k);
    int pi, qi, d;
    bit emit, is_err;
    exp_t e;
    pi = pidx(p);
    qi = pidx(m_acc);
    emit = 0;
    is_err = 0;
    if (p == 4'b0000) begin
      m_act = 0;
    end else if (pi >= 0) begin
      m_act = 1;
      if (qi >= 0) begin
        d = (pi - qi + 4) % 4;
        emit = 1;
        if (d == 1) begin
          m_dir = 1; m_pos = m_pos + 16'd1;
        end else if (d == 3) begin
          m_dir = 0; m_pos = m_pos - 16'd1;
        end else begin
          m_skip = 1; is_err = 1;
        end
      end
      m_idx = 2'(pi);
    end else begin
      m_ill = 1; m_act = 0; emit = 1; is_err = 1;
    end
    m_acc = p;
    if (emit) begin
      e.cyc = k + 3 + S; e.is_err = is_err; e.dir = m_dir; e.pos = m_pos;
      e.idx = m_idx; e.act = m_act; e.ill = m_ill; e.skip = m_skip;
      sbq.push_back(e);
    end
  endtask

  // Drive a pattern for 'hold' cycles, changing just after a rising edge
  task automatic drive_seg(input logic [3:0] p, input int hold);
    @(negedge clk);
    coil_in = p;
    last_pat = p;
    if (hold >= S && p != m_acc) model_accept(p, cyc);
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic check_state(input string name);
    n_cmp++;
    if (position !== m_pos || phase_idx !== m_idx || active !== m_act ||
        err_illegal !== m_ill || err_skip !== m_skip || step_pulse !== 1'b0 || err_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got pos=%h idx=%0d act=%b ill=%b skip=%b sp=%b ep=%b, expected pos=%h idx=%0d act=%b ill=%b skip=%b sp=0 ep=0",
               name, position, phase_idx, active, err_illegal, err_skip, step_pulse, err_pulse,
               m_pos, m_idx, m_act, m_ill, m_skip);
    end
  endtask

  task automatic do_reset();
    repeat (10) @(negedge clk);
    coil_in = 4'b0000; clear = 0; rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    m_acc = 0; m_pos = 0; m_dir = 0; m_act = 0; m_ill = 0; m_skip = 0; m_idx = 0;
    last_pat = 0; step_seen = 0;
    n_cmp++;
    if ({step_pulse, step_dir, position, phase_idx, active, moving, err_pulse, err_illegal, err_skip} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got sp=%b dir=%b pos=%h idx=%0d act=%b mov=%b ep=%b ill=%b skip=%b, expected all 0",
               step_pulse, step_dir, position, phase_idx, active, moving, err_pulse, err_illegal, err_skip);
    end
  endtask

  task automatic do_clear();
    repeat (8) @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    m_pos = 0; m_ill = 0; m_skip = 0;
    check_state("after_clear");
  endtask

  // Monitor: pop on every output event, and track moving every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (step_pulse || err_pulse) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: cyc=%0d sp=%b ep=%b pos=%h, expected no event", cyc, step_pulse, err_pulse, position);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (!e.is_err) begin
            last_step = e.cyc;
            step_seen = 1;
          end
          if (cyc != e.cyc || err_pulse !== e.is_err || step_pulse !== !e.is_err || step_dir !== e.dir ||
              position !== e.pos || phase_idx !== e.idx || active !== e.act ||
              err_illegal !== e.ill || err_skip !== e.skip) begin
            n_bad++;
            $display("FAIL event: got cyc=%0d sp=%b ep=%b dir=%b pos=%h idx=%0d act=%b ill=%b skip=%b, expected cyc=%0d sp=%b ep=%b dir=%b pos=%h idx=%0d act=%b ill=%b skip=%b",
                     cyc, step_pulse, err_pulse, step_dir, position, phase_idx, active, err_illegal, err_skip,
                     e.cyc, !e.is_err, e.is_err, e.dir, e.pos, e.idx, e.act, e.ill, e.skip);
          end
        end
      end
      n_cmp++;
      if (moving !== (step_seen && (cyc - last_step) < IDLE)) begin
        n_bad++;
        $display("FAIL moving: cyc=%0d got %b, expected %b (last step cyc %0d)", cyc, moving,
                 step_seen && (cyc - last_step) < IDLE, last_step);
      end
    end
  end

  initial begin
    logic [3:0] p;
    int hold, wait_cyc;

    do_reset();

    // forward rotation
    drive_seg(4'b0011, 8); drive_seg(4'b0110, 8); drive_seg(4'b1100, 8);
    drive_seg(4'b1001, 8); drive_seg(4'b0011, 8);
    repeat (30) @(negedge clk);
    check_state("forward_seq");

    // reverse rotation from reset
    do_reset();
    drive_seg(4'b1001, 8); drive_seg(4'b1100, 8); drive_seg(4'b0110, 8);
    drive_seg(4'b0011, 8); drive_seg(4'b1001, 8);
    repeat (8) @(negedge clk);
    check_state("reverse_seq");

    // one-cycle glitch is filtered
    drive_seg(4'b0011, 8); drive_seg(4'b0110, 1); drive_seg(4'b0011, 8);
    repeat (4) @(negedge clk);
    check_state("glitch");

    // skipped phase, then clear
    drive_seg(4'b1100, 8);
    check_state("skip");
    do_clear();

    // illegal pattern and recovery
    drive_seg(4'b0110, 8); drive_seg(4'b0111, 8);
    check_state("illegal");
    drive_seg(4'b0110, 8);
    check_state("illegal_recover");
    drive_seg(4'b0000, 8);
    check_state("deenergised");

    // positive wrap of the position counter
    drive_seg(4'b0011, 8);
    do_clear();
    for (int i = 0; i < 32767; i++) drive_seg(phases[(int'(m_idx) + 1) % 4], 2);
    repeat (8) @(negedge clk);
    check_state("pos_7fff");
    drive_seg(phases[(int'(m_idx) + 1) % 4], 8);
    check_state("pos_wrap_8000");

    // random walk
    for (int i = 0; i < 600; i++) begin
      do begin
        case ($urandom_range(0, 9))
          0: p = 4'b0000;
          1: begin
            do p = 4'($urandom_range(1, 15)); while (pidx(p) >= 0);
          end
          2, 3, 4: p = phases[$urandom_range(0, 3)];
          default: p = (pidx(last_pat) >= 0) ?
                       phases[(pidx(last_pat) + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4] :
                       phases[$urandom_range(0, 3)];
        endcase
      end while (p == last_pat);
      hold = ($urandom_range(0, 15) == 0) ? 25 : int'($urandom_range(1, 6));
      drive_seg(p, hold);
    end

    // drain the scoreboard with a bounded wait
    wait_cyc = 0;
    while (sbq.size() != 0 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected events never seen, expected 0 outstanding", sbq.size());
    end
    repeat (4) @(negedge clk);
    check_state("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
